// File: rtl/serial_link_ctrl_pkg.sv
// Shared register map, CTRL layout and isolation FSM state encoding
// for the serial link control/status register block.
package serial_link_ctrl_pkg;

  localparam logic [3:0] CTRL_OFFSET     = 4'h0;
  localparam logic [3:0] ISOLATED_OFFSET = 4'h4;
  localparam logic [3:0] ALLOC_TX_OFFSET = 4'h8;
  localparam logic [3:0] ALLOC_RX_OFFSET = 4'hC;

  localparam int unsigned CTRL_CLK_ENA_BIT = 0;
  localparam int unsigned CTRL_RESET_N_BIT = 1;
  localparam int unsigned CTRL_ISO_IN_BIT  = 8;
  localparam int unsigned CTRL_ISO_OUT_BIT = 9;

  localparam int unsigned ISO_STATUS_LSB  = 0;
  localparam int unsigned ISO_TIMEOUT_LSB = 8;

  // Only implemented CTRL bits survive reset-value loading
  localparam logic [31:0] CTRL_MASK = 32'h0000_0303;

  typedef enum logic [1:0] {
    ISO_ACTIVE    = 2'd0,
    ISO_ISOLATING = 2'd1,
    ISO_ISOLATED  = 2'd2,
    ISO_RELEASING = 2'd3
  } iso_state_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [21:0] rsvd_hi;
    logic        iso_out;
    logic        iso_in;
    logic [5:0]  rsvd_lo;
    logic        reset_n;
    logic        clk_ena;
  } ctrl_reg_t;

endpackage

// File: rtl/serial_link_ctrl_regs_if.sv
// Register-bus request/response bundle between software master and the
// serial link control register block.
interface serial_link_ctrl_regs_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                 reg_req_valid_i;
  logic                 reg_req_write_i;
  logic [AddrWidth-1:0] reg_req_addr_i;
  logic [DataWidth-1:0] reg_req_wdata_i;
  logic [3:0]           reg_req_wstrb_i;
  logic                 reg_rsp_ready_o;
  logic [DataWidth-1:0] reg_rsp_rdata_o;
  logic                 reg_rsp_error_o;

  modport master (
    output reg_req_valid_i, reg_req_write_i, reg_req_addr_i,
           reg_req_wdata_i, reg_req_wstrb_i,
    input  reg_rsp_ready_o, reg_rsp_rdata_o, reg_rsp_error_o
  );

  modport slave (
    input  reg_req_valid_i, reg_req_write_i, reg_req_addr_i,
           reg_req_wdata_i, reg_req_wstrb_i,
    output reg_rsp_ready_o, reg_rsp_rdata_o, reg_rsp_error_o
  );
endinterface

// File: rtl/serial_link_iso_fsm.sv
// One AXI-port isolation handshake FSM with a saturating timeout counter
// and a sticky timeout flag (set beats software clear).
module serial_link_iso_fsm
  import serial_link_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_1,
  input  logic rst_1_n,
  input  logic i_iso_bit,
  input  logic i_isolated,
  input  logic i_sticky_clr,
  output logic o_isolate_req,
  output logic o_status,
  output logic o_sticky
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles);

  iso_state_e          r_state, w_state_d;
  logic [CntWidth-1:0] r_cnt, w_cnt_d;
  logic                r_req, r_status, r_sticky;
  logic                w_waiting, w_hit, w_sticky_d;

  // Next state, counter and sticky flag
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_waiting = (r_state == ISO_ISOLATING) || (r_state == ISO_RELEASING);
    case (r_state)
      ISO_ISOLATING: begin
        if (i_isolated)      w_state_d = ISO_ISOLATED;
        else if (!i_iso_bit) w_state_d = ISO_RELEASING;
      end
      ISO_ISOLATED:  if (!i_iso_bit) w_state_d = ISO_RELEASING;
      ISO_RELEASING: begin
        if (!i_isolated)    w_state_d = ISO_ACTIVE;
        else if (i_iso_bit) w_state_d = ISO_ISOLATING;
      end
      ISO_ACTIVE:    if (i_iso_bit) w_state_d = ISO_ISOLATING;
      default:       w_state_d = ISO_ISOLATING;
    endcase
    if (w_state_d != r_state)              w_cnt_d = '0;
    else if (w_waiting && r_cnt != CntMax) w_cnt_d = r_cnt + CntWidth'(1);
    // Flag fires only on the cycle the counter first reaches the limit
    w_hit      = (w_cnt_d == CntMax) && (r_cnt != CntMax);
    w_sticky_d = w_hit | (r_sticky & ~i_sticky_clr);
  end

  always_ff @(posedge clk_1 or posedge rst_1_n) begin
    if (rst_1_n) begin
      r_state  <= ISO_ISOLATING;
      r_cnt    <= '0;
      r_req    <= 1'b1;
      r_status <= 1'b1;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_req    <= (w_state_d == ISO_ISOLATING) || (w_state_d == ISO_ISOLATED);
      r_status <= (w_state_d != ISO_ACTIVE);
      r_sticky <= w_sticky_d;
    end
  end

  assign o_isolate_req = r_req;
  assign o_status      = r_status;
  assign o_sticky      = r_sticky;

endmodule

// File: rtl/serial_link_ctrl_regs.sv
// Serial link control/status register block: register-bus responder,
// link clock/reset/allocator configuration and per-port isolation control.
module serial_link_ctrl_regs
  import serial_link_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] CtrlRstVal    = 32'h300
) (
  input  logic                      clk_1,
  input  logic                      rst_1_n,
  serial_link_ctrl_regs_if.slave    reg_bus,
  output logic                      clk_ena_o,
  output logic                      link_rst_no,
  output logic [1:0]                isolate_req_o,
  input  logic [1:0]                isolated_i,
  output logic [1:0]                alloc_tx_cfg_o,
  output logic [1:0]                alloc_rx_cfg_o
);

  bus_state_e           r_state, w_state_d;
  logic                 r_ready, w_ready_d;
  logic [DataWidth-1:0] r_rdata, w_rdata_d;
  logic                 r_error, w_error_d;
  ctrl_reg_t            r_ctrl, w_ctrl_d;
  logic [1:0]           r_tx, w_tx_d, r_rx, w_rx_d;
  logic                 r_clk_ena, r_link_rst_n;
  logic [1:0]           r_tx_o, r_rx_o;
  logic [1:0]           w_sticky_clr, w_status, w_sticky;
  logic                 w_dec_err;
  logic [3:0]           w_off;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;
  logic                 w_unused_bits;

  assign w_off     = reg_bus.reg_req_addr_i[3:0];
  assign w_wdata   = 32'(reg_bus.reg_req_wdata_i);
  assign w_wstrb   = reg_bus.reg_req_wstrb_i;
  assign w_dec_err = (|reg_bus.reg_req_addr_i[AddrWidth-1:4]) || (w_off[1:0] != 2'b00);
  assign w_unused_bits = ^{w_wdata[31:10], w_wdata[7:2], w_wstrb[3:2]};

  // Bus FSM: decode and act in IDLE, respond for one cycle in RESP
  always_comb begin
    w_state_d    = r_state;
    w_ready_d    = 1'b0;
    w_rdata_d    = r_rdata;
    w_error_d    = r_error;
    w_ctrl_d     = r_ctrl;
    w_tx_d       = r_tx;
    w_rx_d       = r_rx;
    w_sticky_clr = 2'b00;
    case (r_state)
      BUS_IDLE: begin
        if (reg_bus.reg_req_valid_i) begin
          w_state_d = BUS_RESP;
          w_ready_d = 1'b1;
          w_error_d = w_dec_err;
          w_rdata_d = '0;
          if (!w_dec_err && reg_bus.reg_req_write_i) begin
            case (w_off)
              CTRL_OFFSET: begin
                if (w_wstrb[0]) begin
                  w_ctrl_d.clk_ena = w_wdata[CTRL_CLK_ENA_BIT];
                  w_ctrl_d.reset_n = w_wdata[CTRL_RESET_N_BIT];
                end
                if (w_wstrb[1]) begin
                  w_ctrl_d.iso_in  = w_wdata[CTRL_ISO_IN_BIT];
                  w_ctrl_d.iso_out = w_wdata[CTRL_ISO_OUT_BIT];
                end
              end
              ISOLATED_OFFSET: if (w_wstrb[1]) w_sticky_clr = w_wdata[ISO_TIMEOUT_LSB +: 2];
              ALLOC_TX_OFFSET: if (w_wstrb[0]) w_tx_d = w_wdata[1:0];
              ALLOC_RX_OFFSET: if (w_wstrb[0]) w_rx_d = w_wdata[1:0];
              default: ;
            endcase
          end else if (!w_dec_err) begin
            case (w_off)
              CTRL_OFFSET:     w_rdata_d = DataWidth'(r_ctrl);
              ISOLATED_OFFSET: w_rdata_d = DataWidth'({w_sticky, 6'b0, w_status});
              ALLOC_TX_OFFSET: w_rdata_d = DataWidth'(r_tx);
              ALLOC_RX_OFFSET: w_rdata_d = DataWidth'(r_rx);
              default:         w_rdata_d = '0;
            endcase
          end
        end
      end
      BUS_RESP: w_state_d = BUS_IDLE;
      default:  w_state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst_1_n) begin
    if (rst_1_n) begin
      r_state      <= BUS_IDLE;
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_error      <= 1'b0;
      r_ctrl       <= ctrl_reg_t'(CtrlRstVal & CTRL_MASK);
      r_tx         <= 2'b00;
      r_rx         <= 2'b00;
      r_clk_ena    <= 1'b0;
      r_link_rst_n <= 1'b0;
      r_tx_o       <= 2'b00;
      r_rx_o       <= 2'b00;
    end else begin
      r_state      <= w_state_d;
      r_ready      <= w_ready_d;
      r_rdata      <= w_rdata_d;
      r_error      <= w_error_d;
      r_ctrl       <= w_ctrl_d;
      r_tx         <= w_tx_d;
      r_rx         <= w_rx_d;
      r_clk_ena    <= r_ctrl.clk_ena;
      r_link_rst_n <= r_ctrl.reset_n;
      r_tx_o       <= r_tx;
      r_rx_o       <= r_rx;
    end
  end

  serial_link_iso_fsm #(.TimeoutCycles(TimeoutCycles)) u_iso_in (
    .clk_1         (clk_1),
    .rst_1_n       (rst_1_n),
    .i_iso_bit     (r_ctrl.iso_in),
    .i_isolated    (isolated_i[0]),
    .i_sticky_clr  (w_sticky_clr[0]),
    .o_isolate_req (isolate_req_o[0]),
    .o_status      (w_status[0]),
    .o_sticky      (w_sticky[0])
  );

  serial_link_iso_fsm #(.TimeoutCycles(TimeoutCycles)) u_iso_out (
    .clk_1         (clk_1),
    .rst_1_n       (rst_1_n),
    .i_iso_bit     (r_ctrl.iso_out),
    .i_isolated    (isolated_i[1]),
    .i_sticky_clr  (w_sticky_clr[1]),
    .o_isolate_req (isolate_req_o[1]),
    .o_status      (w_status[1]),
    .o_sticky      (w_sticky[1])
  );

  assign reg_bus.reg_rsp_ready_o = r_ready;
  assign reg_bus.reg_rsp_rdata_o = r_rdata;
  assign reg_bus.reg_rsp_error_o = r_error;
  assign clk_ena_o      = r_clk_ena;
  assign link_rst_no    = r_link_rst_n;
  assign alloc_tx_cfg_o = r_tx_o;
  assign alloc_rx_cfg_o = r_rx_o;

endmodule

// File: tb/tb_serial_link_ctrl_regs.sv
// Directed, table-driven bench for serial_link_ctrl_regs with hand-built
// sequences for isolation handshakes, timeouts and reset abort.
module tb_serial_link_ctrl_regs;

  logic       clk_1;
  logic       rst_1_n;
  logic       clk_ena_o, link_rst_no;
  logic [1:0] isolate_req_o, isolated_i, alloc_tx_cfg_o, alloc_rx_cfg_o;
  int         total = 0;
  int         bad   = 0;

  serial_link_ctrl_regs_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  serial_link_ctrl_regs #(
    .AddrWidth(32), .DataWidth(32), .TimeoutCycles(16), .CtrlRstVal(32'h300)
  ) dut (
    .clk_1          (clk_1),
    .rst_1_n        (rst_1_n),
    .reg_bus        (bus.slave),
    .clk_ena_o      (clk_ena_o),
    .link_rst_no    (link_rst_no),
    .isolate_req_o  (isolate_req_o),
    .isolated_i     (isolated_i),
    .alloc_tx_cfg_o (alloc_tx_cfg_o),
    .alloc_rx_cfg_o (alloc_rx_cfg_o)
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drives one request, checks ready arrives after one edge and pulses once
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    int waited;
    bus.reg_req_valid_i = 1'b1;
    bus.reg_req_write_i = wr;
    bus.reg_req_addr_i  = addr;
    bus.reg_req_wdata_i = wdata;
    bus.reg_req_wstrb_i = strb;
    @(posedge clk_1); #1;
    chk("rsp_latency", 32'(bus.reg_rsp_ready_o), 32'd1);
    waited = 0;
    while (!bus.reg_rsp_ready_o && waited < 8) begin
      @(posedge clk_1); #1;
      waited++;
    end
    if (!bus.reg_rsp_ready_o) chk("rsp_timeout", 32'd0, 32'd1);
    rdata = bus.reg_rsp_rdata_o;
    err   = bus.reg_rsp_error_o;
    bus.reg_req_valid_i = 1'b0;
    @(posedge clk_1); #1;
    chk("rsp_pulse", 32'(bus.reg_rsp_ready_o), 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    logic e;
    access(1'b0, addr, 32'h0, 4'h0, d, e);
    chk(nm, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] d;
    logic e;
    access(1'b1, addr, data, strb, d, e);
    chk("wr_err", 32'(e), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        seen;
    rst_1_n    = 1'b1;
    isolated_i = 2'b00;
    bus.reg_req_valid_i = 1'b0;
    bus.reg_req_write_i = 1'b0;
    bus.reg_req_addr_i  = '0;
    bus.reg_req_wdata_i = '0;
    bus.reg_req_wstrb_i = '0;
    repeat (2) @(posedge clk_1);
    #1;
    chk("rst_ready",   32'(bus.reg_rsp_ready_o), 32'd0);
    chk("rst_rdata",   bus.reg_rsp_rdata_o, 32'd0);
    chk("rst_error",   32'(bus.reg_rsp_error_o), 32'd0);
    chk("rst_clk_ena", 32'(clk_ena_o), 32'd0);
    chk("rst_link_rn", 32'(link_rst_no), 32'd0);
    chk("rst_iso_req", 32'(isolate_req_o), 32'd3);
    chk("rst_tx",      32'(alloc_tx_cfg_o), 32'd0);
    @(negedge clk_1);
    rst_1_n = 1'b0;
    @(posedge clk_1); #1;

    // Bring-up reads while both ports still isolating
    rd(32'h0, 32'h300, "rd_ctrl_rst");
    rd(32'h4, 32'h003, "rd_iso_rst");

    // Both transitions stuck: timeout flags set, then W1C of bit 8 only
    repeat (20) @(posedge clk_1);
    #1;
    rd(32'h4, 32'h303, "rd_iso_timeout");
    wr(32'h4, 32'h100, 4'b0010);
    rd(32'h4, 32'h203, "rd_iso_w1c_in");
    wr(32'h4, 32'h200, 4'b0010);
    rd(32'h4, 32'h003, "rd_iso_w1c_out");

    isolated_i = 2'b11;
    wr(32'h0, 32'h303, 4'b0011);
    @(posedge clk_1); #1;
    chk("clk_ena_on",  32'(clk_ena_o), 32'd1);
    chk("link_rn_on",  32'(link_rst_no), 32'd1);
    chk("iso_req_kept", 32'(isolate_req_o), 32'd3);

    // Release isolation: request drops, status holds until ack drops
    wr(32'h0, 32'h003, 4'b0011);
    chk("iso_req_rel", 32'(isolate_req_o), 32'd0);
    rd(32'h4, 32'h003, "rd_iso_releasing");
    isolated_i = 2'b00;
    repeat (2) @(posedge clk_1);
    #1;
    rd(32'h4, 32'h000, "rd_iso_active");

    vt[0]  = '{1'b1, 32'h8,    32'h3,         4'h0, 32'h0,   1'b0};
    vt[1]  = '{1'b0, 32'h8,    32'h0,         4'h0, 32'h0,   1'b0};
    vt[2]  = '{1'b1, 32'h8,    32'h3,         4'h1, 32'h0,   1'b0};
    vt[3]  = '{1'b0, 32'h8,    32'h0,         4'h0, 32'h3,   1'b0};
    vt[4]  = '{1'b1, 32'hC,    32'hFFFF_FFFE, 4'hF, 32'h0,   1'b0};
    vt[5]  = '{1'b0, 32'hC,    32'h0,         4'h0, 32'h2,   1'b0};
    vt[6]  = '{1'b1, 32'h0,    32'hFFFF_FCFC, 4'hF, 32'h0,   1'b0};
    vt[7]  = '{1'b0, 32'h0,    32'h0,         4'h0, 32'h000, 1'b0};
    vt[8]  = '{1'b1, 32'h0,    32'h0000_0303, 4'h1, 32'h0,   1'b0};
    vt[9]  = '{1'b0, 32'h0,    32'h0,         4'h0, 32'h003, 1'b0};
    vt[10] = '{1'b1, 32'h4,    32'h3,         4'hF, 32'h0,   1'b0};
    vt[11] = '{1'b0, 32'h4,    32'h0,         4'h0, 32'h000, 1'b0};
    vt[12] = '{1'b0, 32'h10,   32'h0,         4'h0, 32'h0,   1'b1};
    vt[13] = '{1'b0, 32'h2,    32'h0,         4'h0, 32'h0,   1'b1};
    vt[14] = '{1'b1, 32'h9,    32'h0,         4'hF, 32'h0,   1'b1};
    vt[15] = '{1'b1, 32'h100C, 32'h0,         4'hF, 32'h0,   1'b1};
    vt[16] = '{1'b0, 32'h8,    32'h0,         4'h0, 32'h3,   1'b0};
    vt[17] = '{1'b0, 32'hC,    32'h0,         4'h0, 32'h2,   1'b0};
    vt[18] = '{1'b0, 32'h0,    32'h0,         4'h0, 32'h003, 1'b0};

    for (int i = 0; i < 19; i++) begin
      access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, d, e);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_rdata);
    end
    chk("tx_port",  32'(alloc_tx_cfg_o), 32'd3);
    chk("rx_port",  32'(alloc_rx_cfg_o), 32'd2);
    chk("clk_port", 32'(clk_ena_o), 32'd1);
    chk("rst_port", 32'(link_rst_no), 32'd1);
    chk("req_port", 32'(isolate_req_o), 32'd0);

    // Sticky set and W1C clear land on the same edge: set wins
    wr(32'h0, 32'h303, 4'b0010);
    repeat (15) @(posedge clk_1);
    #1;
    wr(32'h4, 32'h300, 4'b0010);
    rd(32'h4, 32'h303, "sticky_set_wins");

    // Reset during a pending request aborts it without a response
    bus.reg_req_valid_i = 1'b1;
    bus.reg_req_write_i = 1'b0;
    bus.reg_req_addr_i  = 32'h0;
    #2 rst_1_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_1); #1;
      seen = seen | bus.reg_rsp_ready_o;
    end
    bus.reg_req_valid_i = 1'b0;
    @(negedge clk_1);
    rst_1_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_1); #1;
      seen = seen | bus.reg_rsp_ready_o;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_req",    32'(isolate_req_o), 32'd3);
    chk("abort_clk",    32'(clk_ena_o), 32'd0);
    rd(32'h0, 32'h300, "abort_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
